verify_ram: RTL and testbench

VERIFY_RAM -- requirements
Module: verify_ram

---
 rtl/verify_ram_pkg.sv | 26 ++
 rtl/verify_ram_byte_compare.sv | 12 +
 rtl/verify_ram.sv | 234 +++++++++++++++++++++++
 tb/tb_verify_ram.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verify_ram_pkg.sv
// Bank geometry shared with the fill stage, plus FSM state types for the readback checker.
package verify_ram_pkg;

  localparam int unsigned CYCLES_PER_RAM_BLOCK = 4;
  localparam int unsigned RAM_BLOCKS_PER_BANK  = 8;
  localparam int unsigned RAM_BLOCK_SIZE       = 256;
  localparam int unsigned BEATS_PER_BANK       = CYCLES_PER_RAM_BLOCK * RAM_BLOCKS_PER_BANK;

  typedef enum logic {
    AR_IDLE,
    AR_ISSUE
  } ar_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_RECV,
    R_DRAIN
  } r_state_e;

  function automatic logic [63:0] beat_addr(input logic [63:0] base,
                                            input logic [63:0] idx,
                                            input int unsigned bytes_per_beat);
    return base + idx * 64'(bytes_per_beat);
  endfunction

endpackage

// File: rtl/verify_ram_byte_compare.sv
// All-bytes-equal reduction of one data beat against the fill pattern.
module byte_compare #(
  parameter int unsigned DW         = 512,
  parameter logic [7:0]  FILL_VALUE = 8'hFC
) (
  input  logic [DW-1:0] data,
  output logic          all_equal
);

  assign all_equal = (data == {(DW/8){FILL_VALUE}});

endmodule

// File: rtl/verify_ram.sv
// Reads back one RAM bank over AXI and counts beats that differ from the fill pattern.
module verify_ram
  import verify_ram_pkg::*;
#(
  parameter int unsigned DW         = 512,
  parameter logic [7:0]  FILL_VALUE = 8'hFC,
  parameter logic [63:0] BASE_ADDR  = 64'h10_0000_0000
) (
  input  logic            ram_clk,
  input  logic            ram_reset,
  input  logic            start,
  output logic            idle,
  output logic [63:0]     elapsed,
  output logic [31:0]     mismatch_count,
  output logic [63:0]     first_bad_addr,
  output logic            resp_error,
  output logic [3:0]      M_AXI_ARID,
  output logic [63:0]     M_AXI_ARADDR,
  output logic [7:0]      M_AXI_ARLEN,
  output logic [2:0]      M_AXI_ARSIZE,
  output logic [1:0]      M_AXI_ARBURST,
  output logic            M_AXI_ARLOCK,
  output logic [3:0]      M_AXI_ARCACHE,
  output logic [2:0]      M_AXI_ARPROT,
  output logic [3:0]      M_AXI_ARQOS,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,
  input  logic [DW-1:0]   M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RLAST,
  input  logic            M_AXI_RVALID,
  output logic            M_AXI_RREADY,
  output logic [3:0]      M_AXI_AWID,
  output logic [63:0]     M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic            M_AXI_AWLOCK,
  output logic [3:0]      M_AXI_AWCACHE,
  output logic [2:0]      M_AXI_AWPROT,
  output logic [3:0]      M_AXI_AWQOS,
  output logic            M_AXI_AWVALID,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WLAST,
  output logic            M_AXI_WVALID,
  output logic            M_AXI_BREADY
);

  localparam int unsigned BYTES_PER_BEAT = DW / 8;
  localparam int unsigned BEAT_W  = $clog2(BEATS_PER_BANK + 1);
  localparam int unsigned BURST_W = $clog2(CYCLES_PER_RAM_BLOCK + 1);
  localparam int unsigned AR_W    = $clog2(RAM_BLOCKS_PER_BANK + 1);

  ar_state_e         ar_state_q, ar_state_d;
  logic              arvalid_q, arvalid_d;
  logic [63:0]       araddr_q, araddr_d;
  logic [AR_W-1:0]   ar_cnt_q, ar_cnt_d;
  r_state_e          r_state_q, r_state_d;
  logic              idle_q, idle_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BURST_W-1:0] burst_beat_q, burst_beat_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic              cmp_bad_q, cmp_bad_d;
  logic [BEAT_W-1:0] cmp_idx_q, cmp_idx_d;
  logic [63:0]       elapsed_q, elapsed_d;
  logic [31:0]       mismatch_q, mismatch_d;
  logic [63:0]       first_bad_q, first_bad_d;
  logic              resp_err_q, resp_err_d;

  logic all_equal;
  logic go, ar_hs, r_hs, last_exp;

  byte_compare #(
    .DW         (DW),
    .FILL_VALUE (FILL_VALUE)
  ) u_byte_compare (
    .data      (M_AXI_RDATA),
    .all_equal (all_equal)
  );

  always_comb begin
    ar_state_d   = ar_state_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    ar_cnt_d     = ar_cnt_q;
    r_state_d    = r_state_q;
    idle_d       = idle_q;
    beat_cnt_d   = beat_cnt_q;
    burst_beat_d = burst_beat_q;
    elapsed_d    = elapsed_q;
    mismatch_d   = mismatch_q;
    first_bad_d  = first_bad_q;
    resp_err_d   = resp_err_q;

    go       = start && idle_q;
    ar_hs    = arvalid_q && M_AXI_ARREADY;
    r_hs     = M_AXI_RVALID && !idle_q && (r_state_q == R_RECV);
    last_exp = (burst_beat_q == BURST_W'(CYCLES_PER_RAM_BLOCK - 1));

    cmp_valid_d = r_hs;
    cmp_bad_d   = r_hs && !all_equal;
    cmp_idx_d   = r_hs ? beat_cnt_q : cmp_idx_q;

    case (ar_state_q)
      AR_IDLE: begin
        if (go) begin
          ar_state_d = AR_ISSUE;
          arvalid_d  = 1'b1;
          araddr_d   = BASE_ADDR;
          ar_cnt_d   = '0;
        end
      end
      AR_ISSUE: begin
        if (ar_hs) begin
          if (ar_cnt_q == AR_W'(RAM_BLOCKS_PER_BANK - 1)) begin
            arvalid_d  = 1'b0;
            ar_state_d = AR_IDLE;
          end else begin
            ar_cnt_d = ar_cnt_q + 1'b1;
            araddr_d = araddr_q + 64'(RAM_BLOCK_SIZE);
          end
        end
      end
      default: ar_state_d = AR_IDLE;
    endcase

    // Compare result from the previous cycle's beat lands here, independent of this cycle's handshake.
    if (cmp_valid_q && cmp_bad_q) begin
      if (mismatch_q != '1) mismatch_d = mismatch_q + 32'd1;
      if (mismatch_q == '0) first_bad_d = beat_addr(BASE_ADDR, 64'(cmp_idx_q), BYTES_PER_BEAT);
    end

    if (!idle_q) elapsed_d = elapsed_q + 64'd1;

    case (r_state_q)
      R_IDLE: begin
        if (go) begin
          r_state_d    = R_RECV;
          idle_d       = 1'b0;
          beat_cnt_d   = '0;
          burst_beat_d = '0;
          mismatch_d   = '0;
          resp_err_d   = 1'b0;
          elapsed_d    = '0;
        end
      end
      R_RECV: begin
        if (r_hs) begin
          if (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != last_exp) resp_err_d = 1'b1;
          burst_beat_d = last_exp ? '0 : burst_beat_q + 1'b1;
          beat_cnt_d   = beat_cnt_q + 1'b1;
          if (beat_cnt_q == BEAT_W'(BEATS_PER_BANK - 1)) r_state_d = R_DRAIN;
        end
      end
      R_DRAIN: begin
        r_state_d = R_IDLE;
        idle_d    = 1'b1;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ram_clk or posedge ram_reset) begin
    if (ram_reset) begin
      ar_state_q   <= AR_IDLE;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      ar_cnt_q     <= '0;
      r_state_q    <= R_IDLE;
      idle_q       <= 1'b1;
      beat_cnt_q   <= '0;
      burst_beat_q <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_bad_q    <= 1'b0;
      cmp_idx_q    <= '0;
      elapsed_q    <= '0;
      mismatch_q   <= '0;
      first_bad_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      ar_state_q   <= ar_state_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      ar_cnt_q     <= ar_cnt_d;
      r_state_q    <= r_state_d;
      idle_q       <= idle_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_beat_q <= burst_beat_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_bad_q    <= cmp_bad_d;
      cmp_idx_q    <= cmp_idx_d;
      elapsed_q    <= elapsed_d;
      mismatch_q   <= mismatch_d;
      first_bad_q  <= first_bad_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign idle           = idle_q;
  assign elapsed        = elapsed_q;
  assign mismatch_count = mismatch_q;
  assign first_bad_addr = first_bad_q;
  assign resp_error     = resp_err_q;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = 8'(CYCLES_PER_RAM_BLOCK - 1);
  assign M_AXI_ARSIZE  = 3'($clog2(BYTES_PER_BEAT));
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARQOS   = '0;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = ~idle_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = '0;
  assign M_AXI_AWLEN   = '0;
  assign M_AXI_AWSIZE  = '0;
  assign M_AXI_AWBURST = '0;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = '0;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWQOS   = '0;
  assign M_AXI_AWVALID = 1'b0;
  assign M_AXI_WDATA   = '0;
  assign M_AXI_WSTRB   = '0;
  assign M_AXI_WLAST   = 1'b0;
  assign M_AXI_WVALID  = 1'b0;
  assign M_AXI_BREADY  = 1'b0;

endmodule

// File: tb/tb_verify_ram.sv
// Bench for verify_ram: AXI read slave backed by a beat array, plus a pass-level behavioural model.
module tb_verify_ram;

  localparam int          DW    = 512;
  localparam int          BEATS = 32;
  localparam int          NAR   = 8;
  localparam logic [63:0] BASE  = 64'h10_0000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            idle;
  logic [63:0]     elapsed;
  logic [31:0]     mismatch_count;
  logic [63:0]     first_bad_addr;
  logic            resp_error;
  logic [3:0]      ARID, ARCACHE, ARQOS, AWID, AWCACHE, AWQOS;
  logic [63:0]     ARADDR, AWADDR;
  logic [7:0]      ARLEN, AWLEN;
  logic [2:0]      ARSIZE, ARPROT, AWSIZE, AWPROT;
  logic [1:0]      ARBURST, AWBURST;
  logic            ARLOCK, ARVALID, AWLOCK, AWVALID, WLAST, WVALID, BREADY;
  logic            ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0]   RDATA, WDATA;
  logic [1:0]      RRESP;
  logic [DW/8-1:0] WSTRB;

  always #5 clk = ~clk;

  verify_ram #(
    .DW         (DW),
    .FILL_VALUE (8'hFC),
    .BASE_ADDR  (BASE)
  ) dut (
    .ram_clk        (clk),
    .ram_reset      (rst),
    .start          (start),
    .idle           (idle),
    .elapsed        (elapsed),
    .mismatch_count (mismatch_count),
    .first_bad_addr (first_bad_addr),
    .resp_error     (resp_error),
    .M_AXI_ARID     (ARID),
    .M_AXI_ARADDR   (ARADDR),
    .M_AXI_ARLEN    (ARLEN),
    .M_AXI_ARSIZE   (ARSIZE),
    .M_AXI_ARBURST  (ARBURST),
    .M_AXI_ARLOCK   (ARLOCK),
    .M_AXI_ARCACHE  (ARCACHE),
    .M_AXI_ARPROT   (ARPROT),
    .M_AXI_ARQOS    (ARQOS),
    .M_AXI_ARVALID  (ARVALID),
    .M_AXI_ARREADY  (ARREADY),
    .M_AXI_RDATA    (RDATA),
    .M_AXI_RRESP    (RRESP),
    .M_AXI_RLAST    (RLAST),
    .M_AXI_RVALID   (RVALID),
    .M_AXI_RREADY   (RREADY),
    .M_AXI_AWID     (AWID),
    .M_AXI_AWADDR   (AWADDR),
    .M_AXI_AWLEN    (AWLEN),
    .M_AXI_AWSIZE   (AWSIZE),
    .M_AXI_AWBURST  (AWBURST),
    .M_AXI_AWLOCK   (AWLOCK),
    .M_AXI_AWCACHE  (AWCACHE),
    .M_AXI_AWPROT   (AWPROT),
    .M_AXI_AWQOS    (AWQOS),
    .M_AXI_AWVALID  (AWVALID),
    .M_AXI_WDATA    (WDATA),
    .M_AXI_WSTRB    (WSTRB),
    .M_AXI_WLAST    (WLAST),
    .M_AXI_WVALID   (WVALID),
    .M_AXI_BREADY   (BREADY)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] beat_data [BEATS];
  int rresp_err_beat  = -1;
  int rlast_flip_beat = -1;
  int stall_pct       = 0;

  // pass-level model state
  int          exp_mm;
  logic [63:0] exp_first;
  logic        exp_resp;
  int          ar_seen, beats_seen;
  longint      model_elapsed;
  bit          pass_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_clean();
    for (int b = 0; b < BEATS; b++) beat_data[b] = {(DW/8){8'hFC}};
    rresp_err_beat  = -1;
    rlast_flip_beat = -1;
  endtask

  task automatic corrupt(input int beat, input int byte_i, input logic [7:0] v);
    beat_data[beat][byte_i*8 +: 8] = v;
  endtask

  task automatic set_expect();
    exp_mm    = 0;
    exp_first = '0;
    for (int b = 0; b < BEATS; b++) begin
      bit bad = 0;
      for (int k = 0; k < DW/8; k++)
        if (beat_data[b][k*8 +: 8] != 8'hFC) bad = 1;
      if (bad) begin
        if (exp_mm == 0) exp_first = BASE + 64'(b) * 64;
        exp_mm++;
      end
    end
    exp_resp = (rresp_err_beat >= 0) || (rlast_flip_beat >= 0);
  endtask

  // AXI read slave: addresses are queued on AR, beats served in order from beat_data.
  initial begin : slave
    logic [63:0] ar_q [$];
    logic [63:0] ar_addr_s;
    bit ar_hs, r_hs;
    int rbeat, g;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0;
    rbeat = 0;
    forever begin
      @(negedge clk);
      ar_hs     = ARVALID && ARREADY;
      r_hs      = RVALID && RREADY;
      ar_addr_s = ARADDR;
      @(posedge clk);
      #1;
      if (rst) begin
        ar_q.delete();
        rbeat = 0;
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
      end else begin
        if (ar_hs) ar_q.push_back(ar_addr_s);
        if (r_hs) begin
          rbeat++;
          if (rbeat == 4) begin
            void'(ar_q.pop_front());
            rbeat = 0;
          end
        end
        ARREADY = ($urandom_range(99) >= stall_pct);
        if (!(RVALID && !r_hs)) begin
          if (ar_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
            g = int'((ar_q[0] - BASE) >> 6) + rbeat;
            RDATA  = (g >= 0 && g < BEATS) ? beat_data[g] : '0;
            RRESP  = (g == rresp_err_beat) ? 2'b10 : 2'b00;
            RLAST  = (rbeat == 3) ^ (g == rlast_flip_beat);
            RVALID = 1'b1;
          end else begin
            RVALID = 1'b0;
          end
        end
      end
    end
  end

  // Compare process: per-cycle protocol checks and end-of-pass result checks.
  initial begin : monitor
    bit          prev_idle, prev_arv, prev_arr;
    logic [63:0] prev_addr;
    prev_idle = 1; prev_arv = 0; prev_arr = 0; prev_addr = '0;
    ar_seen = 0; beats_seen = 0; model_elapsed = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_idle = 1; prev_arv = 0; prev_arr = 0;
      end else begin
        if (start && idle) begin
          ar_seen = 0; beats_seen = 0; model_elapsed = 0;
        end
        chk("rready_is_not_idle", 64'(RREADY), 64'(!idle));
        chk("write_and_ar_side_consts_zero",
            64'(|{AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS,
                  AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY, ARID, ARLOCK, ARCACHE, ARPROT, ARQOS}),
            64'd0);
        if (ARVALID) begin
          chk("ar_len_size_burst", 64'({ARLEN, ARSIZE, ARBURST}), 64'({8'd3, 3'd6, 2'd1}));
          if (prev_arv && !prev_arr) chk("araddr_stable_while_stalled", ARADDR, prev_addr);
          if (ARREADY) begin
            chk("araddr_sequence", ARADDR, BASE + 64'(ar_seen) * 256);
            ar_seen++;
          end
        end
        if (RVALID && RREADY) beats_seen++;
        if (!idle) model_elapsed++;
        if (!prev_idle && idle) begin
          chk("pass_ar_count", 64'(ar_seen), 64'(NAR));
          chk("pass_beat_count", 64'(beats_seen), 64'(BEATS));
          chk("pass_mismatch_count", 64'(mismatch_count), 64'(exp_mm));
          if (exp_mm > 0) chk("pass_first_bad_addr", first_bad_addr, exp_first);
          chk("pass_resp_error", 64'(resp_error), 64'(exp_resp));
          chk("pass_elapsed", elapsed, 64'(model_elapsed));
          chk("pass_arvalid_low", 64'(ARVALID), 64'd0);
          pass_done = 1;
        end
        prev_idle = idle; prev_arv = ARVALID; prev_arr = ARREADY; prev_addr = ARADDR;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_pass();
    for (int c = 0; c < 4000 && !pass_done; c++) @(negedge clk);
    chk("pass_completed_in_budget", 64'(pass_done), 64'd1);
  endtask

  task automatic run_pass();
    set_expect();
    pass_done = 0;
    pulse_start();
    wait_pass();
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < 2000 && beats_seen < n; c++) @(negedge clk);
    chk("beats_reached_in_budget", 64'(beats_seen >= n), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_idle"}, 64'(idle), 64'd1);
    chk({tag, "_arvalid"}, 64'(ARVALID), 64'd0);
    chk({tag, "_rready"}, 64'(RREADY), 64'd0);
    chk({tag, "_elapsed"}, elapsed, 64'd0);
    chk({tag, "_mismatch"}, 64'(mismatch_count), 64'd0);
    chk({tag, "_first_bad"}, first_bad_addr, 64'd0);
    chk({tag, "_resp_error"}, 64'(resp_error), 64'd0);
  endtask

  initial begin : main
    fill_clean();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // clean bank, no stalls
    fill_clean(); stall_pct = 0;
    run_pass();
    chk("clean_mismatch", 64'(mismatch_count), 64'd0);
    chk("clean_resp_error", 64'(resp_error), 64'd0);
    chk("clean_idle", 64'(idle), 64'd1);

    // two corrupted beats: first is beat 9 -> 0x10_0000_0240
    fill_clean();
    corrupt(9, 5, 8'h00);
    corrupt(20, 0, 8'h00);
    run_pass();
    chk("two_bad_mismatch", 64'(mismatch_count), 64'd2);
    chk("two_bad_first_addr", first_bad_addr, 64'h10_0000_0240);

    // 50% stalls on both channels
    fill_clean(); stall_pct = 50;
    run_pass();
    chk("stall_mismatch", 64'(mismatch_count), 64'd0);
    chk("stall_resp_error", 64'(resp_error), 64'd0);
    chk("stall_elapsed_gt_32", 64'(elapsed > 64'd32), 64'd1);

    // RRESP error on beat 3, early RLAST on second beat of burst 5
    fill_clean(); stall_pct = 20;
    rresp_err_beat  = 3;
    rlast_flip_beat = 21;
    run_pass();
    chk("resp_error_set", 64'(resp_error), 64'd1);
    repeat (5) @(negedge clk);
    chk("resp_error_sticky", 64'(resp_error), 64'd1);
    fill_clean();
    set_expect();
    pass_done = 0;
    pulse_start();
    @(negedge clk);
    chk("resp_error_cleared_by_start", 64'(resp_error), 64'd0);
    wait_pass();

    // second start mid-pass must be ignored
    fill_clean(); corrupt(30, 63, 8'h7E); stall_pct = 10;
    set_expect();
    pass_done = 0;
    pulse_start();
    wait_beats(5);
    pulse_start();
    wait_pass();
    chk("restart_ignored_first_bad", first_bad_addr, 64'h10_0000_0780);

    // reset at beat 15 aborts the pass
    fill_clean(); corrupt(2, 1, 8'h11); stall_pct = 0;
    set_expect();
    pass_done = 0;
    pulse_start();
    wait_beats(4);
    pulse_start();
    wait_beats(15);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("midpass_reset");
    chk("no_pass_end_after_reset", 64'(pass_done), 64'd0);
    fill_clean();
    run_pass();
    chk("post_reset_mismatch", 64'(mismatch_count), 64'd0);

    // randomized passes
    for (int p = 0; p < 4; p++) begin
      int n;
      fill_clean();
      stall_pct = $urandom_range(0, 70);
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v == 8'hFC) v = 8'h00;
        corrupt($urandom_range(0, BEATS-1), $urandom_range(0, DW/8-1), v);
      end
      if ($urandom_range(0, 3) == 0) rresp_err_beat = $urandom_range(0, BEATS-1);
      run_pass();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
